spi_slave_rx: RTL and testbench
===============================

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the number of received bytes buffered ahead of the I2C converter (power of two, 2..16).
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the flop count of each SPI input synchronizer (2..3).
REQ-003 Port clk  input  1  SHALL be the single system clock; all state is clocked on its rising edge.
REQ-004 Port reset  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 Port spi_sclk  input  1  SHALL be the external SPI clock (mode 0, asynchronous to clk, frequency at most clk/8).
REQ-006 Port spi_mosi  input  1  SHALL be the serial data input, MSB first.
REQ-007 Port spi_cs_n  input  1  SHALL be the active-low chip select framing each transfer.
REQ-008 Port data  output  8  SHALL present the FIFO head byte to the downstream spitoi2c block.
REQ-009 Port start  output  1  SHALL be high whenever the FIFO is non-empty (valid for data).
REQ-010 Port ready  input  1  SHALL be the downstream accept; start&&ready in a cycle pops one byte.
REQ-011 Port clr_flags  input  1  SHALL be a synchronous clear of both sticky flags.
REQ-012 Port overflow  output  1  SHALL be a sticky flag set when a received byte is dropped.
REQ-013 Port frame_err  output  1  SHALL be a sticky flag set when a frame ends mid-byte.
REQ-014 Port fifo_count  output  clog2(FIFO_DEPTH)+1  SHALL report current FIFO occupancy.

Function
REQ-015 spi_sclk, spi_mosi and spi_cs_n SHALL each pass through SYNC_STAGES flops, followed by one history flop for edge detection.
REQ-016 A sclk rising edge SHALL be detected when the history flop is 0 and the synchronized value is 1; spi_mosi SHALL be sampled from its synchronizer in that same cycle.
REQ-017 While synchronized cs_n is low, each detected rising edge SHALL shift the sampled bit into an 8-bit shift register LSB end and increment a 3-bit bit counter.
REQ-018 On the 8th rising edge (counter wrapping 7->0), the completed byte SHALL be pushed into the FIFO in the following clk cycle.
REQ-019 Bytes SHALL continue back-to-back within one cs_n-low frame without a gap.
REQ-020 While synchronized cs_n is high, the bit counter SHALL be held at 0 and sclk edges SHALL be ignored.
REQ-021 A synchronized cs_n rising edge with bit counter non-zero SHALL discard the partial byte, push nothing, and set frame_err.
REQ-022 data SHALL equal the FIFO head byte with no added register stage; start SHALL equal (fifo_count != 0).
REQ-023 A pop SHALL occur when start&&ready; ready while start is low SHALL have no effect.
REQ-024 A push with FIFO full and no pop in the same cycle SHALL drop the byte, set overflow, and leave FIFO contents unchanged.
REQ-025 A push and a pop in the same cycle SHALL both succeed at any occupancy, including full, with fifo_count unchanged.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH.
REQ-027 clr_flags SHALL clear overflow and frame_err; a same-cycle set event SHALL take priority over the clear.
REQ-028 Latency from the 8th synchronized sclk rising edge to start high on an empty FIFO SHALL be 2 clk cycles.

Reset
REQ-029 reset low SHALL immediately clear all synchronizers to their idle values (sclk 0, mosi 0, cs_n 1), the shift register, bit counter, pointers, count and flags.
REQ-030 During reset, data SHALL be 8'h00, start 0, overflow 0, frame_err 0 and fifo_count 0.
REQ-031 Reset asserted mid-byte SHALL lose the partial byte with no push and no frame_err after release.
REQ-032 Reset deassertion SHALL be synchronized to clk by the integrating block; spi_slave_rx assumes a release clean to clk.

Verification
REQ-033 One frame, byte 8'hAA, ready=1 -> start high 2 cycles after the 8th edge with data=8'hAA, popped in one cycle, fifo_count returns to 0.
REQ-034 One frame, bytes 8'h01..8'h05 with ready=0 -> fifo_count=4, overflow=1, and after releasing ready the pops yield data 01,02,03,04 in order.
REQ-035 Five bits, then cs_n high -> frame_err=1, fifo_count=0; clr_flags pulse -> frame_err=0.
REQ-036 FIFO full, then ready=1 in the push cycle of 8'h5A -> no overflow, fifo_count stays 4, and 8'h5A is read out last.
REQ-037 reset pulsed low after 3 bits of 8'hC3, then a full 8'h3C frame -> only 8'h3C is delivered, frame_err=0.
REQ-038 sclk at clk/8 with random ready toggling over 64 bytes -> output stream equals the input stream whenever overflow stays 0.

Source files
------------

// File: rtl/spi_slave_rx.sv
// SPI mode-0 receive front end: synchronizes the SPI pins into clk, deserializes
// MSB-first bytes and buffers them in a small FIFO for the downstream I2C converter.
module spi_slave_rx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          spi_sclk,
  input  logic                          spi_mosi,
  input  logic                          spi_cs_n,
  output logic [7:0]                    data,
  output logic                          start,
  input  logic                          ready,
  input  logic                          clr_flags,
  output logic                          overflow,
  output logic                          frame_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sclk_hist;
  logic                   r_cs_hist;

  logic [7:0]             r_shift;
  logic [2:0]             r_bit_cnt;
  logic                   r_push_vld;

  logic [7:0]             r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_count;
  logic                   r_overflow;
  logic                   r_frame_err;

  logic w_sclk_s, w_mosi_s, w_cs_s;
  logic w_sclk_rise, w_cs_rise;
  logic w_pop, w_full, w_push_ok, w_ovf_set, w_ferr_set;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_hist;
  assign w_cs_rise   = w_cs_s & ~r_cs_hist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sclk_hist <= 1'b0;
      r_cs_hist   <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_sclk_hist <= w_sclk_s;
      r_cs_hist   <= w_cs_s;
    end
  end

  // The completed byte is pushed straight from r_shift one cycle later; the
  // sclk rate limit guarantees no further shift happens before the write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_push_vld <= 1'b0;
    end else begin
      r_push_vld <= 1'b0;
      if (w_cs_s) begin
        r_bit_cnt <= '0;
      end else if (w_sclk_rise) begin
        r_shift   <= {r_shift[6:0], w_mosi_s};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) r_push_vld <= 1'b1;
      end
    end
  end

  assign w_pop      = start & ready;
  assign w_full     = (r_count == DEPTH_L);
  assign w_push_ok  = r_push_vld & (~w_full | w_pop);
  assign w_ovf_set  = r_push_vld & w_full & ~w_pop;
  assign w_ferr_set = w_cs_rise & (r_bit_cnt != 3'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_ovf_set)      r_overflow <= 1'b1;
      else if (clr_flags) r_overflow <= 1'b0;
      if (w_ferr_set)     r_frame_err <= 1'b1;
      else if (clr_flags) r_frame_err <= 1'b0;
    end
  end

  assign data       = r_mem[r_rd_ptr];
  assign start      = (r_count != '0);
  assign fifo_count = r_count;
  assign overflow   = r_overflow;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: table-driven frames, hand-written corner
// sequences, and a randomized stream compared against a queue reference model.
`timescale 1ns/1ps
module tb_spi_slave_rx;

  localparam int DEPTH = 4;
  localparam int SYNC  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_sclk, spi_mosi, spi_cs_n;
  logic [7:0] data;
  logic       start, ready, clr_flags, overflow, frame_err;
  logic [$clog2(DEPTH):0] fifo_count;

  int checks = 0;
  int failures = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  bit rand_mode = 1'b0;

  spi_slave_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_cs_n(spi_cs_n), .data(data), .start(start), .ready(ready),
    .clr_flags(clr_flags), .overflow(overflow), .frame_err(frame_err),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so at negedge start&&ready predicts the pop.
  always @(negedge clk) if (start && ready) got.push_back(data);

  always @(posedge clk) if (rand_mode) begin #1; ready = 1'($urandom); end

  initial begin
    #3_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [15:0] v, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      spi_mosi = v[15-i];
      tick(4);
      spi_sclk = 1'b1;
      tick(4);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b);
    spi_bits({b, 8'h00}, 8);
  endtask

  task automatic cs_lo();
    spi_cs_n = 1'b0;
    tick(4);
  endtask

  task automatic cs_hi();
    tick(4);
    spi_cs_n = 1'b1;
    tick(8);
  endtask

  task automatic clr();
    clr_flags = 1'b1;
    tick(1);
    clr_flags = 1'b0;
  endtask

  function automatic logic [31:0] got_at(input int unsigned i);
    return (i < got.size()) ? {24'h0, got[i]} : 32'h100;
  endfunction

  typedef struct {
    logic [15:0] din;
    int unsigned nbits;
    int unsigned exp_pops;
    logic        exp_ferr;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int lat;
    bit found;
    reset = 1'b0; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1;
    ready = 1'b0; clr_flags = 1'b0;

    tbl[0] = '{16'h5A00, 8, 1, 1'b0};
    tbl[1] = '{16'hC3A5, 16, 2, 1'b0};
    tbl[2] = '{16'hFF00, 8, 1, 1'b0};
    tbl[3] = '{16'h0000, 8, 1, 1'b0};
    tbl[4] = '{16'h8000, 5, 0, 1'b1};
    tbl[5] = '{16'h1234, 12, 1, 1'b1};
    tbl[6] = '{16'h0000, 0, 0, 1'b0};

    // reset values while held in reset
    tick(3);
    chk("rst_data", data, 8'h00);
    chk("rst_start", start, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_count", fifo_count, 0);
    reset = 1'b1;
    tick(4);

    // single byte AA with ready=1: latency, one-cycle pop
    got.delete();
    ready = 1'b1;
    cs_lo();
    spi_bits(16'hAA00, 7);
    spi_mosi = 1'b0;
    tick(4);
    spi_sclk = 1'b1;
    lat = 0; found = 0;
    for (int c = 1; c <= 20 && !found; c++) begin
      tick(1);
      if (start) begin found = 1; lat = c; end
    end
    chk("aa_latency", lat, SYNC + 2);
    chk("aa_data", data, 8'hAA);
    tick(1);
    chk("aa_start_low", start, 0);
    chk("aa_count0", fifo_count, 0);
    spi_sclk = 1'b0;
    cs_hi();
    chk("aa_pops", got.size(), 1);
    chk("aa_byte", got_at(0), 8'hAA);
    ready = 1'b0;

    // table-driven frames with ready held high
    foreach (tbl[k]) begin
      got.delete();
      clr();
      ready = 1'b1;
      cs_lo();
      spi_bits(tbl[k].din, tbl[k].nbits);
      cs_hi();
      tick(4);
      chk($sformatf("tbl%0d_ferr", k), frame_err, tbl[k].exp_ferr);
      chk($sformatf("tbl%0d_pops", k), got.size(), tbl[k].exp_pops);
      for (int unsigned j = 0; j < tbl[k].exp_pops; j++)
        chk($sformatf("tbl%0d_b%0d", k, j), got_at(j), (j == 0) ? tbl[k].din[15:8] : tbl[k].din[7:0]);
      chk($sformatf("tbl%0d_count", k), fifo_count, 0);
      ready = 1'b0;
    end

    // five bytes into a four-deep FIFO with ready low
    clr();
    got.delete();
    cs_lo();
    for (int b = 1; b <= 5; b++) spi_byte(8'(b));
    cs_hi();
    chk("ovf_count", fifo_count, DEPTH);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", data, 8'h01);
    ready = 1'b1;
    tick(10);
    ready = 1'b0;
    chk("ovf_pops", got.size(), DEPTH);
    for (int unsigned j = 0; j < DEPTH; j++) chk($sformatf("ovf_b%0d", j), got_at(j), j + 1);
    chk("ovf_count0", fifo_count, 0);

    // partial frame sets frame_err; clr_flags clears both flags
    cs_lo();
    spi_bits(16'hF800, 5);
    cs_hi();
    chk("ferr_set", frame_err, 1);
    chk("ferr_count", fifo_count, 0);
    clr();
    chk("ferr_clr", frame_err, 0);
    chk("ovf_clr", overflow, 0);

    // full FIFO, simultaneous push and pop of 5A
    got.delete();
    cs_lo();
    spi_byte(8'h11); spi_byte(8'h22); spi_byte(8'h33); spi_byte(8'h44);
    chk("full_count", fifo_count, DEPTH);
    spi_bits(16'h5A00, 7);
    spi_mosi = 1'b0;
    tick(4);
    spi_sclk = 1'b1;
    tick(SYNC + 1);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    tick(2);
    spi_sclk = 1'b0;
    cs_hi();
    chk("pp_ovf", overflow, 0);
    chk("pp_count", fifo_count, DEPTH);
    ready = 1'b1;
    tick(10);
    ready = 1'b0;
    chk("pp_pops", got.size(), 5);
    chk("pp_first", got_at(0), 8'h11);
    chk("pp_last", got_at(4), 8'h5A);

    // reset mid-byte, then a clean frame
    got.delete();
    ready = 1'b1;
    cs_lo();
    spi_bits(16'hC300, 3);
    reset = 1'b0;
    tick(2);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_data", data, 8'h00);
    reset = 1'b1;
    tick(4);
    cs_hi();
    cs_lo();
    spi_byte(8'h3C);
    cs_hi();
    tick(4);
    chk("mid_rst_pops", got.size(), 1);
    chk("mid_rst_byte", got_at(0), 8'h3C);
    chk("mid_rst_ferr", frame_err, 0);
    ready = 1'b0;

    // randomized stream at clk/8 with random ready
    clr();
    got.delete();
    exp_q.delete();
    rand_mode = 1'b1;
    cs_lo();
    for (int n = 0; n < 64; n++) begin
      logic [7:0] b;
      b = 8'($urandom);
      exp_q.push_back(b);
      spi_byte(b);
    end
    cs_hi();
    rand_mode = 1'b0;
    tick(2);
    ready = 1'b1;
    tick(10);
    ready = 1'b0;
    chk("rnd_ovf", overflow, 0);
    chk("rnd_pops", got.size(), exp_q.size());
    foreach (exp_q[j]) chk($sformatf("rnd_b%0d", j), got_at(j), exp_q[j]);
    chk("rnd_count0", fifo_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
